// File: rtl/wall_follower_pkg.sv
// Shared types and constants for the wall-following maze controller.
// Directions are absolute (0=N,1=E,2=S,3=W); offsets are relative to heading.
// Priority orders pack four 2-bit offsets, entry 0 (LSBs) tried first.
package wall_follower_pkg;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_DECIDE    = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

   localparam logic [1:0] REL_FRONT = 2'd0;
   localparam logic [1:0] REL_RIGHT = 2'd1;
   localparam logic [1:0] REL_BACK  = 2'd2;
   localparam logic [1:0] REL_LEFT  = 2'd3;

   // Right-hand: right, front, left, back. Left-hand: left, front, right, back.
   localparam logic [7:0] RH_ORDER = {REL_BACK, REL_LEFT, REL_FRONT, REL_RIGHT};
   localparam logic [7:0] LH_ORDER = {REL_BACK, REL_RIGHT, REL_FRONT, REL_LEFT};

endpackage

// File: rtl/wall_dir_picker.sv
// Combinational move chooser: first open relative offset in hand-rule order.
// Latency: zero cycles (pure combinational).
// Backpressure: none; found=0 when all four directions are blocked.
module wall_dir_picker
   import wall_follower_pkg::*;
(
   input  logic [1:0] heading,
   input  logic [3:0] sensor,
   input  logic       hand,
   output logic       found,
   output dir_t       abs_dir,
   output logic       is_back
);

   logic [7:0] order;
   logic [1:0] rel;
   dir_t       cand;

   // Walk the order from lowest priority to highest so the best open choice wins.
   always_comb begin
      found   = 1'b0;
      abs_dir = dir_t'(heading);
      is_back = 1'b0;
      rel     = REL_FRONT;
      cand    = dir_t'(heading);
      order   = hand ? LH_ORDER : RH_ORDER;
      for (int i = 3; i >= 0; i--) begin
         rel  = order[2*i +: 2];
         cand = dir_t'(heading + rel);
         if (!sensor[cand]) begin
            found   = 1'b1;
            abs_dir = cand;
            is_back = (rel == REL_BACK);
         end
      end
   end

endmodule

// File: rtl/wall_follower_ctrl.sv
// Wall-following navigation FSM; optional u-turn counter under WALL_FOLLOWER_UTURN_CNT_EN.
// Latency: start at T raises move_valid at T+2+SETTLE_CYCLES; settle repeats after each move_done.
// Backpressure: move_valid/move_dir held until move_ready; abort drops the request at once.
module wall_follower_ctrl
   import wall_follower_pkg::*;
#(
   parameter int STEP_W        = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int MAX_STEPS     = 0,
   parameter int INIT_HEADING  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              hand_sel,
   input  logic [3:0]        sensor,
   input  logic              goal,
   output logic              move_valid,
   output logic [1:0]        move_dir,
   input  logic              move_ready,
   input  logic              move_done,
   output logic [1:0]        heading,
   output logic [STEP_W-1:0] step_count,
   output logic              busy,
   output logic              done,
   output logic              stuck,
   output logic              timeout,
   output logic [7:0]        uturn_count
);

   localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LIMIT  = STEP_W'(MAX_STEPS);
   localparam logic              LIMIT_EN    = (MAX_STEPS != 0);
   localparam dir_t              HEAD_INIT   = dir_t'(2'(INIT_HEADING));

   state_t            state_q, state_d;
   dir_t              heading_q, heading_d;
   dir_t              move_dir_q, move_dir_d;
   logic              move_valid_q, move_valid_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              stuck_q, stuck_d;
   logic              timeout_q, timeout_d;
   logic              hand_q, hand_d;
   logic [7:0]        settle_q, settle_d;

   logic pick_found;
   dir_t pick_dir;
   logic pick_back;
   logic hs;

`ifdef WALL_FOLLOWER_UTURN_CNT_EN
   logic       back_q, back_d;
   logic [7:0] uturn_q, uturn_d;
`else
   // The back flag only matters when u-turns are being counted.
   logic unused_pick_back;
   assign unused_pick_back = pick_back;
`endif

   wall_dir_picker u_picker (
      .heading (heading_q),
      .sensor  (sensor),
      .hand    (hand_q),
      .found   (pick_found),
      .abs_dir (pick_dir),
      .is_back (pick_back)
   );

   assign hs = move_valid_q && move_ready;

   // Next-state and datapath updates; abort overrides everything else.
   always_comb begin
      state_d      = state_q;
      heading_d    = heading_q;
      move_dir_d   = move_dir_q;
      move_valid_d = move_valid_q;
      step_d       = step_q;
      stuck_d      = stuck_q;
      timeout_d    = timeout_q;
      hand_d       = hand_q;
      settle_d     = settle_q;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
      back_d       = back_q;
      uturn_d      = uturn_q;
`endif
      if (abort) begin
         state_d      = ST_IDLE;
         move_valid_d = 1'b0;
         stuck_d      = 1'b0;
         timeout_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FINISH: begin
               if (start) begin
                  state_d   = ST_SETTLE;
                  heading_d = HEAD_INIT;
                  step_d    = '0;
                  stuck_d   = 1'b0;
                  timeout_d = 1'b0;
                  hand_d    = hand_sel;
                  settle_d  = SETTLE_LOAD;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
                  uturn_d   = '0;
`endif
               end
            end
            ST_SETTLE: begin
               if (settle_q == '0) state_d = ST_DECIDE;
               else                settle_d = settle_q - 8'd1;
            end
            ST_DECIDE: begin
               if (goal) begin
                  state_d = ST_FINISH;
               end else if (LIMIT_EN && (step_q == STEP_LIMIT)) begin
                  state_d   = ST_FINISH;
                  timeout_d = 1'b1;
               end else if (!pick_found) begin
                  state_d = ST_FINISH;
                  stuck_d = 1'b1;
               end else begin
                  state_d      = ST_ISSUE;
                  move_dir_d   = pick_dir;
                  heading_d    = pick_dir;
                  move_valid_d = 1'b1;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
                  back_d       = pick_back;
`endif
               end
            end
            ST_ISSUE: begin
               if (hs) begin
                  state_d      = ST_WAIT_DONE;
                  move_valid_d = 1'b0;
                  if (step_q != '1) step_d = step_q + 1'b1;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
                  if (back_q && (uturn_q != 8'hFF)) uturn_d = uturn_q + 8'd1;
`endif
               end
            end
            ST_WAIT_DONE: begin
               if (move_done) begin
                  state_d  = ST_SETTLE;
                  settle_d = SETTLE_LOAD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         heading_q    <= HEAD_INIT;
         move_dir_q   <= DIR_N;
         move_valid_q <= 1'b0;
         step_q       <= '0;
         stuck_q      <= 1'b0;
         timeout_q    <= 1'b0;
         hand_q       <= 1'b0;
         settle_q     <= '0;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
         back_q       <= 1'b0;
         uturn_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         heading_q    <= heading_d;
         move_dir_q   <= move_dir_d;
         move_valid_q <= move_valid_d;
         step_q       <= step_d;
         stuck_q      <= stuck_d;
         timeout_q    <= timeout_d;
         hand_q       <= hand_d;
         settle_q     <= settle_d;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
         back_q       <= back_d;
         uturn_q      <= uturn_d;
`endif
      end
   end

   assign move_valid = move_valid_q;
   assign move_dir   = move_dir_q;
   assign heading    = heading_q;
   assign step_count = step_q;
   assign stuck      = stuck_q;
   assign timeout    = timeout_q;
   assign done       = (state_q == ST_FINISH);
   assign busy       = (state_q == ST_SETTLE) || (state_q == ST_DECIDE) ||
                       (state_q == ST_ISSUE)  || (state_q == ST_WAIT_DONE);
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
   assign uturn_count = uturn_q;
`else
   assign uturn_count = '0;
`endif

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Bench for wall_follower_ctrl: schedule-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wall_follower_ctrl;

   localparam int S    = 4;
   localparam int MAXS = 3;

   logic        clk = 1'b0;
   logic        rst, start, abort, hand_sel, goal, move_ready, move_done;
   logic [3:0]  sensor;
   logic        move_valid, busy, done, stuck, timeout;
   logic [1:0]  move_dir, heading;
   logic [15:0] step_count;
   logic [7:0]  uturn_count;

   always #5 clk = ~clk;

   wall_follower_ctrl #(
      .STEP_W(16), .SETTLE_CYCLES(S), .MAX_STEPS(MAXS), .INIT_HEADING(0)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .hand_sel(hand_sel),
      .sensor(sensor), .goal(goal), .move_valid(move_valid), .move_dir(move_dir),
      .move_ready(move_ready), .move_done(move_done), .heading(heading),
      .step_count(step_count), .busy(busy), .done(done), .stuck(stuck),
      .timeout(timeout), .uturn_count(uturn_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

`ifdef WALL_FOLLOWER_UTURN_CNT_EN
   localparam logic [7:0] UTURN_ONE = 8'd1;
`else
   localparam logic [7:0] UTURN_ONE = 8'd0;
`endif

   // ---------------- reference model ----------------
   // A run is a schedule: count down the settle wait, decide, then wait for
   // the handshake and the motion-done pulse before counting down again.
   logic        m_active, m_finished, m_valid, m_waitdone, m_stuck, m_timeout, m_hand, m_back;
   logic [1:0]  m_dir, m_heading;
   logic [15:0] m_steps;
   logic [7:0]  m_uturn;
   int          m_wait;

   function automatic int pick(input int hd, input logic [3:0] sens, input logic lh,
                               output int off_o);
      int offs[4];
      if (lh) offs = '{3, 0, 1, 2};
      else    offs = '{1, 0, 3, 2};
      for (int k = 0; k < 4; k++) begin
         int d;
         d = (hd + offs[k]) % 4;
         if (!sens[d]) begin
            off_o = offs[k];
            return d;
         end
      end
      off_o = -1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int d, off;
      if (rst) begin
         m_active = 0; m_finished = 0; m_valid = 0; m_waitdone = 0;
         m_stuck = 0; m_timeout = 0; m_hand = 0; m_back = 0;
         m_dir = 0; m_heading = 0; m_steps = 0; m_uturn = 0; m_wait = -1;
      end else if (abort) begin
         m_active = 0; m_finished = 0; m_valid = 0; m_waitdone = 0;
         m_stuck = 0; m_timeout = 0; m_wait = -1;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1; m_finished = 0; m_heading = 0; m_steps = 0;
            m_stuck = 0; m_timeout = 0; m_uturn = 0; m_hand = hand_sel; m_wait = S;
         end
      end else begin
         if (m_wait > 0) begin
            m_wait--;
         end else if (m_wait == 0) begin
            m_wait = -1;
            if (goal) begin
               m_active = 0; m_finished = 1;
            end else if (MAXS != 0 && int'(m_steps) == MAXS) begin
               m_active = 0; m_finished = 1; m_timeout = 1;
            end else begin
               d = pick(int'(m_heading), sensor, m_hand, off);
               if (d < 0) begin
                  m_active = 0; m_finished = 1; m_stuck = 1;
               end else begin
                  m_dir = 2'(d); m_heading = 2'(d); m_valid = 1; m_back = (off == 2);
               end
            end
         end else if (m_valid) begin
            if (move_ready) begin
               m_valid = 0; m_waitdone = 1;
               if (m_steps != 16'hFFFF) m_steps++;
`ifdef WALL_FOLLOWER_UTURN_CNT_EN
               if (m_back && m_uturn != 8'hFF) m_uturn++;
`endif
            end
         end else if (m_waitdone && move_done) begin
            m_waitdone = 0; m_wait = S;
         end
      end
   end

   logic cmp_en = 1'b0;
   logic valid_seen;

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en)
         check("model_cmp",
               {7'd0, busy, done, stuck, timeout, move_valid, move_dir, heading, step_count, uturn_count},
               {7'd0, m_active, m_finished, m_stuck, m_timeout, m_valid, m_dir, m_heading, m_steps, m_uturn});
      if (move_valid) valid_seen = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic launch(input logic h, input logic [3:0] s);
      sensor = s; hand_sel = h; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!move_valid && cyc < 50) begin tick(); cyc++; end
      check("valid_wait", move_valid, 1);
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 50) begin tick(); c++; end
      check("done_wait", done, 1);
   endtask

   task automatic handshake();
      move_ready = 1'b1; tick(); move_ready = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   initial begin
      int c;
      rst = 1; start = 0; abort = 0; hand_sel = 0; goal = 0;
      move_ready = 0; move_done = 0; sensor = 4'b0000; valid_seen = 0;
      repeat (3) tick();
      check("rst_heading", heading, 0);
      check("rst_move_dir", move_dir, 0);
      check("rst_busy_done", {busy, done, stuck, timeout, move_valid}, 0);
      check("rst_steps", step_count, 0);
      rst = 0;
      cmp_en = 1;
      tick();

      // Right-hand in the open: turn right, with fixed launch latency.
      launch(0, 4'b0000);
      wait_valid(c);
      check("latency", c, 5);
      check("rh_open_dir", move_dir, 1);
      check("rh_open_heading", heading, 1);
      handshake();
      check("hs_step", step_count, 1);
      check("hs_valid_low", move_valid, 0);
      do_abort();
      check("abort_busy", busy, 0);

      // Right blocked, so go straight.
      launch(0, 4'b0010);
      wait_valid(c);
      check("rh_front_dir", move_dir, 0);
      do_abort();

      // Left-hand in the open turns left.
      launch(1, 4'b0000);
      wait_valid(c);
      check("lh_open_dir", move_dir, 3);
      do_abort();

      // Abort beats start.
      abort = 1; start = 1; tick(); abort = 0; start = 0;
      tick();
      check("abort_over_start", busy, 0);

      // Boxed in: finish stuck without ever requesting a move.
      valid_seen = 0;
      launch(0, 4'b1111);
      wait_done();
      check("stuck_flag", {stuck, timeout}, 2'b10);
      check("stuck_steps", step_count, 0);
      check("stuck_no_valid", valid_seen, 0);

      // Backpressure: request held stable while ready is low (restart from FINISH).
      launch(0, 4'b0000);
      wait_valid(c);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid_dir_step", {move_valid, move_dir, step_count}, {1'b1, 2'd1, 16'd0});
      end
      handshake();
      check("release_step", step_count, 1);
      check("release_valid", move_valid, 0);
      do_abort();

      // Step limit: three moves along an open corridor, then timeout.
      launch(0, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         wait_valid(c);
         if (k == 0) begin
            move_done = 1; tick(); move_done = 0;
            check("spurious_done_ignored", move_valid, 1);
         end
         handshake();
         tick();
         move_done = 1; tick(); move_done = 0;
      end
      wait_done();
      check("timeout_flags", {stuck, timeout}, 2'b01);
      check("timeout_steps", step_count, 3);
      check("timeout_heading", heading, 3);

      // Goal seen at the first decision.
      goal = 1;
      launch(0, 4'b0000);
      wait_done();
      check("goal_flags", {stuck, timeout, step_count}, 0);
      goal = 0;

      // Only the back is open: u-turn, then abort mid-request.
      launch(0, 4'b1011);
      wait_valid(c);
      check("back_dir", move_dir, 2);
      handshake();
      check("uturn_count", uturn_count, UTURN_ONE);
      tick();
      move_done = 1; tick(); move_done = 0;
      wait_valid(c);
      check("second_dir", move_dir, 2);
      do_abort();
      check("abort_mid_issue", {move_valid, busy}, 0);
      check("abort_keeps", {heading, step_count}, {2'd2, 16'd1});
      check("abort_uturn", uturn_count, UTURN_ONE);
      tick();

      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1);
   end

endmodule
